// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial adder/subtractor:
//     - WIDTH_DEFAULT : default operand/result width
//     - state_e       : controller states (IDLE / RUN / DONE)
//     - idx_width()   : width of the bit-index counter for a given WIDTH
// ---------------------------------------------------------------------------
package serial_adder_pkg;

   localparam int unsigned WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Bit-index counter width; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_n_fa_cell.sv
// ---------------------------------------------------------------------------
// fa_cell
//   Single-bit combinational full adder used for the per-bit serial step.
//   Ports:
//     a, b : operand bits
//     ci   : carry in
//     s    : sum bit
//     co   : carry out
// ---------------------------------------------------------------------------
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   always_comb begin
      s  = a ^ b ^ ci;
      co = (a & b) | (a & ci) | (b & ci);
   end

endmodule

// File: rtl/serial_adder_n.sv
// ---------------------------------------------------------------------------
// serial_adder_n
//   Bit-serial adder/subtractor. One bit per clock, LSB first, through a
//   single full-adder cell. sub=0 computes A+B+cin, sub=1 computes A-B
//   (B inverted with carry-in forced to 1).
//
//   Parameters:
//     WIDTH  : operand/result width (2..32)
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     start  : begin an operation (accepted in IDLE or DONE)
//     a, b   : operands, captured when start is accepted
//     cin    : carry-in for add (ignored when sub=1)
//     sub    : 0 = add, 1 = subtract
//     busy   : high during the WIDTH processing cycles
//     done   : one-cycle pulse when sum/cout/ovf are valid
//     sum    : result, held until the next operation completes
//     cout   : final carry-out (sub mode: 1 = no borrow)
//     ovf    : two's-complement overflow
//
//   Build option:
//     SERIAL_ADDER_OVF_EN : when defined, ovf = carry into MSB ^ carry out
//                           of MSB; otherwise ovf is tied to 0.
// ---------------------------------------------------------------------------
module serial_adder_n
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned      IDX_W    = idx_width(WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               carry_q, carry_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WIDTH-2:0]   res_q, res_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               accept;
   logic               fa_s, fa_co;
   logic [WIDTH-1:0]   shift_w;
`ifdef SERIAL_ADDER_OVF_EN
   logic               ovf_q, ovf_d;
`endif

   fa_cell u_fa (
      .a  (a_q[0]),
      .b  (b_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   // Partial result: new sum bit enters at the MSB side. Only WIDTH-1 bits
   // are stored; the last bit goes straight into the output register.
   assign shift_w = {fa_s, res_q};
   assign accept  = start && ((state_q == IDLE) || (state_q == DONE));

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif

      if (accept) begin
         // Subtraction as A + ~B + 1.
         state_d = RUN;
         a_d     = a;
         b_d     = sub ? ~b : b;
         carry_d = sub ? 1'b1 : cin;
         idx_d   = '0;
         busy_d  = 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               a_d     = a_q >> 1;
               b_d     = b_q >> 1;
               carry_d = fa_co;
               res_d   = shift_w[WIDTH-1:1];
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  sum_d   = shift_w;
                  cout_d  = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                  // carry_q is the carry into the MSB on the last step.
                  ovf_d   = carry_q ^ fa_co;
`endif
               end else begin
                  idx_d  = idx_q + IDX_W'(1);
                  busy_d = 1'b1;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf  = ovf_q;
`else
   assign ovf  = 1'b0;
`endif

endmodule
